// File: rtl/iir_stream_checker_if.sv
// Handshake bundle between a stimulus/feeder and iir_stream_checker:
// golden and filter-output streams in, verdict and counters out.
interface iir_stream_checker_if #(
   parameter int NB = 12
);
   logic          vExp;
   logic [NB-1:0] dExp;
   logic          vIn;
   logic [NB-1:0] dIn;
   logic          last;
   logic          mismatch;
   logic [15:0]   err_cnt;
   logic [15:0]   smp_cnt;
   logic          ovf;
   logic          unexp;
   logic          tout;
   logic          done;
   logic          pass;

   modport master (
      output vExp, dExp, vIn, dIn, last,
      input  mismatch, err_cnt, smp_cnt, ovf, unexp, tout, done, pass
   );

   modport slave (
      input  vExp, dExp, vIn, dIn, last,
      output mismatch, err_cnt, smp_cnt, ovf, unexp, tout, done, pass
   );
endinterface

// File: rtl/iir_stream_checker.sv
// Receive-side self-checker: golden samples queue in a FIFO ahead of the filter
// latency; each filter output is popped against the head and compared within TOL.
module iir_stream_checker #(
   parameter int NB      = 12,
   parameter int DEPTH   = 16,
   parameter int TOL     = 0,
   parameter int TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   iir_stream_checker_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t        state_reg, state_next;
   logic [NB-1:0] mem [DEPTH];
   logic [AW:0]   wr_ptr_reg, rd_ptr_reg;
   logic [TW-1:0] timer_reg, timer_next;
   logic [15:0]   err_cnt_reg, err_cnt_next;
   logic [15:0]   smp_cnt_reg, smp_cnt_next;
   logic          mismatch_reg, ovf_reg, unexp_reg, tout_reg;

   logic          fifo_empty, fifo_full, active;
   logic          pop, push, unexp_c, ovf_c, fail_c, timeout_c;
   logic [AW:0]   fifo_count;
   logic [NB-1:0] head;
   logic signed [NB:0] diff;
   logic [NB:0]   mag;
   logic [15:0]   missing;
   logic [16:0]   err_sum;

   assign fifo_count = wr_ptr_reg - rd_ptr_reg;
   assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
   assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign head       = mem[rd_ptr_reg[AW-1:0]];

   // No bypass: a vIn against an empty FIFO is unexpected even if dExp arrives now.
   always_comb begin
      active    = (state_reg != DONE);
      pop       = bus.vIn && !fifo_empty && active;
      unexp_c   = bus.vIn && !pop;
      push      = bus.vExp && active && (!fifo_full || pop);
      ovf_c     = bus.vExp && active && fifo_full && !pop;
      diff      = $signed({bus.dIn[NB-1], bus.dIn}) - $signed({head[NB-1], head});
      mag       = diff[NB] ? $unsigned(-diff) : $unsigned(diff);
      fail_c    = pop && (mag > (NB+1)'(TOL));
   end

   always_comb begin
      state_next = state_reg;
      timer_next = timer_reg;
      timeout_c  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.last)
               state_next = DRAIN;
            else if (bus.vExp || bus.vIn)
               state_next = RUN;
         end
         RUN: begin
            if (bus.last)
               state_next = DRAIN;
         end
         DRAIN: begin
            if (fifo_empty) begin
               state_next = DONE;
            end else if (bus.vIn) begin
               timer_next = '0;
            end else if (timer_reg == TW'(TIMEOUT - 1)) begin
               state_next = DONE;
               timeout_c  = 1'b1;
            end else begin
               timer_next = timer_reg + 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Whatever is still queued when the drain timer expires is reported missing.
   always_comb begin
      missing      = timeout_c ? 16'(fifo_count) : 16'd0;
      err_sum      = {1'b0, err_cnt_reg} + {16'd0, fail_c} + {16'd0, unexp_c} + {1'b0, missing};
      err_cnt_next = err_sum[16] ? 16'hFFFF : err_sum[15:0];
      smp_cnt_next = smp_cnt_reg;
      if (pop && smp_cnt_reg != 16'hFFFF)
         smp_cnt_next = smp_cnt_reg + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr_reg[AW-1:0]] <= bus.dExp;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         timer_reg    <= '0;
         err_cnt_reg  <= '0;
         smp_cnt_reg  <= '0;
         mismatch_reg <= 1'b0;
         ovf_reg      <= 1'b0;
         unexp_reg    <= 1'b0;
         tout_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         timer_reg    <= timer_next;
         err_cnt_reg  <= err_cnt_next;
         smp_cnt_reg  <= smp_cnt_next;
         mismatch_reg <= fail_c;
         if (push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         if (ovf_c)
            ovf_reg <= 1'b1;
         if (unexp_c)
            unexp_reg <= 1'b1;
         if (timeout_c)
            tout_reg <= 1'b1;
      end
   end

   assign bus.mismatch = mismatch_reg;
   assign bus.err_cnt  = err_cnt_reg;
   assign bus.smp_cnt  = smp_cnt_reg;
   assign bus.ovf      = ovf_reg;
   assign bus.unexp    = unexp_reg;
   assign bus.tout     = tout_reg;
   assign bus.done     = (state_reg == DONE);
   assign bus.pass     = (state_reg == DONE) && (err_cnt_reg == 16'd0) && !ovf_reg && !tout_reg;

endmodule

// File: tb/tb_iir_stream_checker.sv
// Directed bench for iir_stream_checker (NB=12, DEPTH=16, TOL=1, TIMEOUT=64)
// with hand-computed expectations checked by immediate assertions.
module tb_iir_stream_checker;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_assert = 0;
   int   n_fail = 0;

   iir_stream_checker_if #(.NB(12)) bus ();

   iir_stream_checker #(
      .NB(12), .DEPTH(16), .TOL(1), .TIMEOUT(64)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   // One clock with the given stream inputs; returns 1 time unit after the edge.
   task automatic cyc(input logic ve, input logic [11:0] de, input logic vi, input logic [11:0] di);
      bus.vExp = ve;
      bus.dExp = de;
      bus.vIn  = vi;
      bus.dIn  = di;
      @(posedge clk);
      #1;
      if (ve || vi)
         $display("t=%0t vExp=%0b dExp=%03h vIn=%0b dIn=%03h -> mismatch=%0b err_cnt=%0d smp_cnt=%0d",
                  $time, ve, de, vi, di, bus.mismatch, bus.err_cnt, bus.smp_cnt);
      bus.vExp = 1'b0;
      bus.vIn  = 1'b0;
   endtask

   task automatic do_reset();
      bus.last = 1'b0;
      bus.vExp = 1'b0;
      bus.vIn  = 1'b0;
      rst_n    = 1'b0;
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
   endtask

   initial begin
      bus.vExp = 1'b0;
      bus.dExp = '0;
      bus.vIn  = 1'b0;
      bus.dIn  = '0;
      bus.last = 1'b0;

      // Test 1: 8 clean samples, 5 idle cycles, then matching outputs.
      do_reset();
      chk("rst_err_cnt", 32'(bus.err_cnt), 0);
      chk("rst_smp_cnt", 32'(bus.smp_cnt), 0);
      chk("rst_flags", {bus.mismatch, bus.ovf, bus.unexp, bus.tout, bus.done, bus.pass}, 0);
      for (int i = 1; i <= 8; i++) cyc(1'b1, 12'(i), 1'b0, 12'h000);
      for (int i = 0; i < 5; i++) cyc(1'b0, 12'h000, 1'b0, 12'h000);
      for (int i = 1; i <= 8; i++) begin
         cyc(1'b0, 12'h000, 1'b1, 12'(i));
         chk("t1_no_mismatch", 32'(bus.mismatch), 0);
      end
      chk("t1_smp_cnt", 32'(bus.smp_cnt), 8);
      bus.last = 1'b1;
      cyc(1'b0, 12'h000, 1'b0, 12'h000);
      chk("t1_not_done_in_drain", 32'(bus.done), 0);
      cyc(1'b0, 12'h000, 1'b0, 12'h000);
      chk("t1_done", 32'(bus.done), 1);
      chk("t1_pass", 32'(bus.pass), 1);
      chk("t1_err_cnt", 32'(bus.err_cnt), 0);

      // Test 2: 4th output corrupted to 0x7FF (expected 0x004).
      do_reset();
      for (int i = 1; i <= 8; i++) cyc(1'b1, 12'(i), 1'b0, 12'h000);
      for (int i = 1; i <= 8; i++) begin
         cyc(1'b0, 12'h000, 1'b1, (i == 4) ? 12'h7FF : 12'(i));
         chk("t2_mismatch_pulse", 32'(bus.mismatch), (i == 4) ? 1 : 0);
         chk("t2_err_cnt_step", 32'(bus.err_cnt), (i >= 4) ? 1 : 0);
      end
      bus.last = 1'b1;
      cyc(1'b0, 12'h000, 1'b0, 12'h000);
      cyc(1'b0, 12'h000, 1'b0, 12'h000);
      chk("t2_smp_cnt", 32'(bus.smp_cnt), 8);
      chk("t2_done", 32'(bus.done), 1);
      chk("t2_pass", 32'(bus.pass), 0);

      // Test 3: tolerance edges around TOL=1, including the -2048 extreme.
      do_reset();
      cyc(1'b1, 12'h800, 1'b0, 12'h000);
      cyc(1'b1, 12'h800, 1'b0, 12'h000);
      cyc(1'b1, 12'h004, 1'b0, 12'h000);
      cyc(1'b1, 12'h005, 1'b0, 12'h000);
      cyc(1'b0, 12'h000, 1'b1, 12'h801);
      chk("t3_diff_p1_ok", 32'(bus.mismatch), 0);
      cyc(1'b0, 12'h000, 1'b1, 12'h7FF);
      chk("t3_diff_4095_fail", 32'(bus.mismatch), 1);
      cyc(1'b0, 12'h000, 1'b1, 12'h006);
      chk("t3_diff_p2_fail", 32'(bus.mismatch), 1);
      cyc(1'b0, 12'h000, 1'b1, 12'h004);
      chk("t3_diff_m1_ok", 32'(bus.mismatch), 0);
      chk("t3_err_cnt", 32'(bus.err_cnt), 2);
      chk("t3_smp_cnt", 32'(bus.smp_cnt), 4);

      // Test 4: 17 pushes into a 16-deep FIFO, then 16 correct outputs.
      do_reset();
      for (int i = 0; i < 17; i++) begin
         cyc(1'b1, 12'(12'h100 + i), 1'b0, 12'h000);
         if (i == 15) chk("t4_no_ovf_at_16", 32'(bus.ovf), 0);
      end
      chk("t4_ovf_at_17", 32'(bus.ovf), 1);
      for (int i = 0; i < 16; i++) cyc(1'b0, 12'h000, 1'b1, 12'(12'h100 + i));
      bus.last = 1'b1;
      cyc(1'b0, 12'h000, 1'b0, 12'h000);
      cyc(1'b0, 12'h000, 1'b0, 12'h000);
      chk("t4_err_cnt", 32'(bus.err_cnt), 0);
      chk("t4_smp_cnt", 32'(bus.smp_cnt), 16);
      chk("t4_done", 32'(bus.done), 1);
      chk("t4_pass", 32'(bus.pass), 0);

      // Test 5: 4 pushed, 2 returned, then silence until the drain timeout.
      do_reset();
      for (int i = 1; i <= 4; i++) cyc(1'b1, 12'(i), 1'b0, 12'h000);
      cyc(1'b0, 12'h000, 1'b1, 12'h001);
      cyc(1'b0, 12'h000, 1'b1, 12'h002);
      bus.last = 1'b1;
      cyc(1'b0, 12'h000, 1'b0, 12'h000);
      for (int i = 0; i < 63; i++) cyc(1'b0, 12'h000, 1'b0, 12'h000);
      chk("t5_no_tout_yet", {bus.tout, bus.done}, 0);
      cyc(1'b0, 12'h000, 1'b0, 12'h000);
      chk("t5_tout", 32'(bus.tout), 1);
      chk("t5_done", 32'(bus.done), 1);
      chk("t5_err_cnt", 32'(bus.err_cnt), 2);
      chk("t5_pass", 32'(bus.pass), 0);
      cyc(1'b1, 12'h055, 1'b0, 12'h000);
      chk("t5_push_ignored_in_done", 32'(bus.ovf), 0);
      cyc(1'b0, 12'h000, 1'b1, 12'h003);
      chk("t5_unexp_in_done", 32'(bus.unexp), 1);
      chk("t5_err_after_unexp", 32'(bus.err_cnt), 3);
      chk("t5_no_mismatch_on_unexp", 32'(bus.mismatch), 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_async_rst_done", {bus.done, bus.tout, bus.unexp}, 0);
      chk("t5_async_rst_err", 32'(bus.err_cnt), 0);

      // Test 6: output with empty FIFO, then asynchronous reset mid-cycle.
      do_reset();
      cyc(1'b0, 12'h000, 1'b1, 12'h005);
      chk("t6_unexp", 32'(bus.unexp), 1);
      chk("t6_err_cnt", 32'(bus.err_cnt), 1);
      chk("t6_smp_cnt", 32'(bus.smp_cnt), 0);
      cyc(1'b1, 12'h009, 1'b0, 12'h000);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_counts", {bus.err_cnt, bus.smp_cnt}, 0);
      chk("t6_rst_flags", {bus.mismatch, bus.ovf, bus.unexp, bus.tout, bus.done, bus.pass}, 0);

      // Test 7: last in IDLE drains an empty FIFO straight to a passing DONE.
      do_reset();
      bus.last = 1'b1;
      cyc(1'b0, 12'h000, 1'b0, 12'h000);
      chk("t7_drain_not_done", 32'(bus.done), 0);
      cyc(1'b0, 12'h000, 1'b0, 12'h000);
      chk("t7_done_pass", {bus.done, bus.pass}, 2'b11);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
